// File: rtl/comparator_bist.sv
// Self-test initiator for a combinational magnitude comparator: sweeps every (a,b)
// pair, samples eq/gt/lt after a settle interval and records mismatches.
module comparator_bist #(
  parameter int W      = 1,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [W-1:0]   a_out,
  output logic [W-1:0]   b_out,
  input  logic           eq_in,
  input  logic           gt_in,
  input  logic           lt_in,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*W:0]   err_count,
  output logic           fail_valid,
  output logic [W-1:0]   fail_a,
  output logic [W-1:0]   fail_b
);

  // state   | meaning
  // S_IDLE  | waiting for start after reset
  // S_DRIVE | vector applied, counting SETTLE cycles
  // S_CHECK | sample flags, update result, advance index
  // S_DONE  | sweep finished, result held until start or rst

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [2*W-1:0]  idx_q, idx_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [2*W:0]    err_q, err_d;
  logic            fv_q, fv_d;
  logic [W-1:0]    fa_q, fa_d;
  logic [W-1:0]    fb_q, fb_d;

  logic [W-1:0]    cur_a, cur_b;
  logic [2:0]      flags_exp;
  logic            mismatch;

  assign cur_a     = idx_q[2*W-1:W];
  assign cur_b     = idx_q[W-1:0];
  assign flags_exp = {cur_a == cur_b, cur_a > cur_b, cur_a < cur_b};
  // zero-hot and multi-hot responses fall out of the full 3-bit compare
  assign mismatch  = ({eq_in, gt_in, lt_in} != flags_exp);

  assign a_out      = cur_a;
  assign b_out      = cur_b;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_a     = fa_q;
  assign fail_b     = fb_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    err_d    = err_q;
    fv_d     = fv_q;
    fa_d     = fa_q;
    fb_d     = fb_q;
    busy     = 1'b0;
    done     = 1'b0;
    pass     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) begin
          done = 1'b1;
          pass = (err_q == '0);
        end
        if (start) begin
          idx_d    = '0;
          settle_d = '0;
          err_d    = '0;
          fv_d     = 1'b0;
          fa_d     = '0;
          fb_d     = '0;
          state_d  = S_DRIVE;
        end
      end
      S_DRIVE: begin
        busy = 1'b1;
        if (settle_q == SW'(SETTLE - 1)) begin
          settle_d = '0;
          state_d  = S_CHECK;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      S_CHECK: begin
        busy = 1'b1;
        if (mismatch) begin
          err_d = err_q + (2*W+1)'(1);
          if (!fv_q) begin
            fv_d = 1'b1;
            fa_d = cur_a;
            fb_d = cur_b;
          end
        end
        if (&idx_q) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + (2*W)'(1);
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      fv_q     <= 1'b0;
      fa_q     <= '0;
      fb_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      fv_q     <= fv_d;
      fa_q     <= fa_d;
      fb_q     <= fb_d;
    end
  end

endmodule

// File: tb/tb_comparator_bist.sv
// Bench for comparator_bist: two instances (W=1/SETTLE=1 and W=2/SETTLE=3) driven by
// a comparator model with selectable faults, checked every cycle against a timing model.
module tb_comparator_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance 0: W=1, SETTLE=1
  logic       rst1, start1, eq1, gt1, lt1, busy1, done1, pass1, fv1;
  logic [0:0] a1, b1, fa1, fb1;
  logic [2:0] err1;
  // instance 1: W=2, SETTLE=3
  logic       rst2, start2, eq2, gt2, lt2, busy2, done2, pass2, fv2;
  logic [1:0] a2, b2, fa2, fb2;
  logic [4:0] err2;

  int fault1 = 0;
  int fault2 = 0;

  comparator_bist #(.W(1), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .a_out(a1), .b_out(b1),
    .eq_in(eq1), .gt_in(gt1), .lt_in(lt1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1));

  comparator_bist #(.W(2), .SETTLE(3)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .a_out(a2), .b_out(b2),
    .eq_in(eq2), .gt_in(gt2), .lt_in(lt2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_valid(fv2), .fail_a(fa2), .fail_b(fb2));

  function automatic logic [2:0] ideal_flags(int a, int b);
    if (a == b) return 3'b100;
    if (a > b)  return 3'b010;
    return 3'b001;
  endfunction

  // fault: 0 good, 1 gt/lt swapped, 2 eq stuck 1, 3 all stuck 0, 4 wrong only at (3,2)
  function automatic logic [2:0] comp_flags(int fault, int a, int b);
    logic [2:0] f;
    f = ideal_flags(a, b);
    case (fault)
      1: f = {f[2], f[0], f[1]};
      2: f[2] = 1'b1;
      3: f = 3'b000;
      4: if (a == 3 && b == 2) f = 3'b001;
      default: ;
    endcase
    return f;
  endfunction

  assign {eq1, gt1, lt1} = comp_flags(fault1, int'(a1), int'(b1));
  assign {eq2, gt2, lt2} = comp_flags(fault2, int'(a2), int'(b2));

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: 0 idle after reset, 1 sweeping (t = cycles since start edge), 2 done
  int m_mode [2] = '{0, 0};
  int m_t    [2] = '{0, 0};
  int m_flt  [2] = '{0, 0};
  bit m_valid[2] = '{1'b0, 1'b0};
  int m_w    [2] = '{1, 2};
  int m_s    [2] = '{1, 3};

  task automatic model_step(input int i, input logic r, input logic s);
    int len;
    len = (1 << (2 * m_w[i])) * (m_s[i] + 1);
    if (r === 1'b1) begin
      m_mode[i]  = 0;
      m_valid[i] = 1'b1;
    end else if ((m_mode[i] == 0 || m_mode[i] == 2) && s === 1'b1) begin
      m_mode[i] = 1;
      m_t[i]    = 0;
      m_flt[i]  = (i == 0) ? fault1 : fault2;
    end else if (m_mode[i] == 1) begin
      m_t[i]++;
      if (m_t[i] == len) m_mode[i] = 2;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, rst1, start1);
    model_step(1, rst2, start2);
  end

  task automatic model_out(input int i, output int ea, output int eb, output int ebusy,
                           output int edone, output int epass, output int eerr,
                           output int efv, output int efa, output int efb);
    int n, per, v, va, vb;
    n = 1 << (2 * m_w[i]);
    per = m_s[i] + 1;
    {ea, eb, ebusy, edone, epass, eerr, efv, efa, efb} = '0;
    if (m_mode[i] != 0) begin
      v = (m_mode[i] == 1) ? m_t[i] / per : n - 1;
      ea = v >> m_w[i];
      eb = v & ((1 << m_w[i]) - 1);
      for (int k = 0; k < n; k++) begin
        va = k >> m_w[i];
        vb = k & ((1 << m_w[i]) - 1);
        // vector k is sampled in its last cycle; result visible from the next one
        if ((m_mode[i] == 2 || k * per + per - 1 < m_t[i]) &&
            comp_flags(m_flt[i], va, vb) != ideal_flags(va, vb)) begin
          eerr++;
          if (efv == 0) begin
            efv = 1; efa = va; efb = vb;
          end
        end
      end
      ebusy = (m_mode[i] == 1) ? 1 : 0;
      edone = (m_mode[i] == 2) ? 1 : 0;
      epass = (edone == 1 && eerr == 0) ? 1 : 0;
    end
  endtask

  always @(negedge clk) begin
    int ea, eb, ebusy, edone, epass, eerr, efv, efa, efb;
    if (m_valid[0]) begin
      model_out(0, ea, eb, ebusy, edone, epass, eerr, efv, efa, efb);
      chk("i0 a_out", 32'(a1), ea);       chk("i0 b_out", 32'(b1), eb);
      chk("i0 busy", 32'(busy1), ebusy);  chk("i0 done", 32'(done1), edone);
      chk("i0 pass", 32'(pass1), epass);  chk("i0 err_count", 32'(err1), eerr);
      chk("i0 fail_valid", 32'(fv1), efv);
      chk("i0 fail_a", 32'(fa1), efa);    chk("i0 fail_b", 32'(fb1), efb);
    end
    if (m_valid[1]) begin
      model_out(1, ea, eb, ebusy, edone, epass, eerr, efv, efa, efb);
      chk("i1 a_out", 32'(a2), ea);       chk("i1 b_out", 32'(b2), eb);
      chk("i1 busy", 32'(busy2), ebusy);  chk("i1 done", 32'(done2), edone);
      chk("i1 pass", 32'(pass2), epass);  chk("i1 err_count", 32'(err2), eerr);
      chk("i1 fail_valid", 32'(fv2), efv);
      chk("i1 fail_a", 32'(fa2), efa);    chk("i1 fail_b", 32'(fb2), efb);
    end
  end

  // Pulse start on one instance and count busy cycles until done (bounded).
  task automatic run_sweep(input int i, output int nbusy);
    bit seen_done;
    nbusy = 0;
    seen_done = 1'b0;
    @(negedge clk);
    if (i == 0) start1 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    if (i == 0) start1 = 1'b0; else start2 = 1'b0;
    for (int k = 0; k < 200 && !seen_done; k++) begin
      if ((i == 0) ? busy1 : busy2) nbusy++;
      if ((i == 0) ? done1 : done2) seen_done = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL sweep_timeout inst %0d: done never rose within budget", i);
    end
  endtask

  int nb;
  logic [1:0] seq [$];
  int exp_seq [8] = '{0, 0, 1, 1, 2, 2, 3, 3};

  initial begin
    rst1 = 1'b1; rst2 = 1'b1; start1 = 1'b0; start2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0; rst2 = 1'b0;
    chk("reset busy", 32'(busy1), 0);
    chk("reset done", 32'(done1), 0);
    chk("reset err_count", 32'(err2), 0);

    // clean sweep, recording the vector sequence
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 0; k < 40 && !done1; k++) begin
      if (busy1) seq.push_back({a1, b1});
      @(negedge clk);
    end
    chk("clean busy cycles", 32'(seq.size()), 8);
    for (int k = 0; k < 8 && k < seq.size(); k++) chk("vector order", 32'(seq[k]), exp_seq[k]);
    chk("clean done", 32'(done1), 1);
    chk("clean pass", 32'(pass1), 1);
    chk("clean fail_valid", 32'(fv1), 0);

    fault1 = 1;
    run_sweep(0, nb);
    chk("swap err_count", 32'(err1), 2);
    chk("swap fail_valid", 32'(fv1), 1);
    chk("swap fail_a", 32'(fa1), 0);
    chk("swap fail_b", 32'(fb1), 1);
    chk("swap pass", 32'(pass1), 0);

    // restart from done with the same fault: result clears then repeats
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("restart done drop", 32'(done1), 0);
    chk("restart pass drop", 32'(pass1), 0);
    chk("restart err cleared", 32'(err1), 0);
    for (int k = 0; k < 40 && !done1; k++) @(negedge clk);
    chk("repeat err_count", 32'(err1), 2);

    fault1 = 2;
    run_sweep(0, nb);
    chk("eq1 err_count", 32'(err1), 2);
    chk("eq1 fail_b", 32'(fb1), 1);
    fault1 = 3;
    run_sweep(0, nb);
    chk("zero err_count", 32'(err1), 4);
    chk("zero fail_a", 32'(fa1), 0);
    chk("zero fail_b", 32'(fb1), 0);

    // start while busy is ignored
    fault1 = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    nb = 1;
    for (int k = 0; k < 40 && !done1; k++) begin
      @(negedge clk);
      if (busy1) nb++;
      start1 = (k == 1 || k == 3);
    end
    start1 = 1'b0;
    chk("ignored start busy cycles", 32'(nb), 8);
    chk("ignored start pass", 32'(pass1), 1);

    // reset mid-sweep
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    chk("abort a_out", 32'(a1), 0);
    chk("abort busy", 32'(busy1), 0);
    chk("abort done", 32'(done1), 0);
    run_sweep(0, nb);
    chk("post-abort busy cycles", 32'(nb), 8);
    chk("post-abort pass", 32'(pass1), 1);

    // wide instance
    run_sweep(1, nb);
    chk("w2 busy cycles", 32'(nb), 64);
    chk("w2 pass", 32'(pass2), 1);
    fault2 = 4;
    run_sweep(1, nb);
    chk("w2 err_count", 32'(err2), 1);
    chk("w2 fail_a", 32'(fa2), 3);
    chk("w2 fail_b", 32'(fb2), 2);
    chk("w2 pass fault", 32'(pass2), 0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
